route_compute_stage: RTL
========================

# route_compute_stage

Registered, parametrised route-computation stage for one router input port. It decodes signed relative {y,x} destination offsets in head flits, selects an output port under XY or YX dimension-order routing, and rewrites the offset field one hop closer to zero. It locks that route for body and tail flits until the tail passes (wormhole). It sits between the input buffer and the switch-allocation arbiters, with a one-deep valid/ready pipeline register.

## Interface
- X_W, 8, width of signed x offset (flit data bits [X_W-1:0])
- Y_W, 8, width of signed y offset (flit data bits [X_W+Y_W-1:X_W])
- DATA_W, 32, flit data width; must be ≥ X_W+Y_W
- ROUTE_MODE, 0, 0 = XY (resolve x first), 1 = YX (resolve y first)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input flit valid
- in_ready  out  1  stage can accept a flit this cycle
- in_head  in  1  flit is a packet head (carries offsets)
- in_tail  in  1  flit is a packet tail (head+tail = single-flit packet)
- in_data  in  DATA_W  flit data
- out_valid  out  1  registered flit valid
- out_ready  in  1  downstream (switch) accepts flit
- out_head, out_tail  out  1 each  registered head/tail flags
- out_data  out  DATA_W  flit data, offset field rewritten on heads
- out_port  out  3  port code: 1 local, 2 north, 3 south, 4 east, 5 west
- out_req  out  5  one-hot request, high to low {west,east,south,north,local}
- err_pulse  out  1  one-cycle protocol-error flag

## Operation
- Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
- Packet FSM, states IDLE (expect head) and LOCKED (mid-packet); reset → IDLE.
- IDLE + accepted head, no tail → LOCKED. IDLE + head+tail → stays IDLE.
- LOCKED + accepted tail → IDLE. LOCKED + body → LOCKED.
- Route on head, x and y read as signed:
  - XY: x>0 east, x−1; x<0 west, x+1; x=0: y>0 north, y−1; y<0 south, y+1; y=0 local, unchanged.
  - YX: y first with the same rules, then x; (0,0) local.
  - Only the offset field is rewritten; data bits above X_W+Y_W pass unchanged.
  - No overflow is possible because offsets only move toward zero. Extreme values (e.g. −128 and +127 at 8 bits) are handled exactly.
- Route register holds out_port/out_req from the head. Body and tail flits reuse it, with data unmodified.
- Error cases (err_pulse=1 for the cycle after the offending accept):
  - Non-head flit accepted in IDLE: dropped. No out_valid, state unchanged.
  - Head accepted in LOCKED: treated as a new head. Route is recomputed and the flit is forwarded. State follows that head's tail bit.
- out_port and out_req always agree. out_req is all-zero only when out_valid=0.

## Timing
- Latency 1 cycle: a flit accepted at edge N appears on out_* after edge N, valid from cycle N+1.
- in_ready = !out_valid | out_ready (combinational). This gives full throughput, one flit per cycle under continuous out_ready.
- Back-pressure: while out_valid & !out_ready, all out_* hold stable and in_ready=0.
- Simultaneous out transfer and in accept in the same cycle: the register is reloaded with the new flit, with no bubble.
- Reset values (async, immediate): out_valid 0, out_head 0, out_tail 0, out_data 0, out_port 0, out_req 0, err_pulse 0, FSM IDLE, route register 0.
- Reset mid-packet discards the held flit and the lock. The first flit after reset must be a head, else the error rule applies.

## Test plan
- XY, head data {y=3,x=−2}, out_ready=1 → next cycle out_port=5, out_req=5'b10000, offset {3,−1}. Then x=0,y=3 → north, {2,0}. Then {0,0} → local, out_req=5'b00001.
- YX mode, head {y=−1,x=4} → south, out_req=5'b00100, offset {0,4}. Next hop {0,4} → east, {0,3}.
- 4-flit packet (head {0,5}, 2 body, tail) with out_ready low for 3 cycles mid-packet → all four flits delivered in order with out_req=5'b01000, body data unmodified, outputs stable while stalled, FSM IDLE after tail.
- Body flit with no prior head → dropped, err_pulse=1 for one cycle, out_valid stays 0. Head in LOCKED → forwarded with new route, err_pulse=1.
- Extremes at 8 bits: {−128,0} → south with y=−127; {0,127} → east with x=126; single-flit head+tail {0,0} → local, FSM remains IDLE.
- Assert rst_n low while holding a stalled body flit → out_valid=0 and out_req=0 immediately. After release, a body flit raises err_pulse.

Source files
------------

// File: rtl/route_compute_stage.sv
// Route-computation stage for one router input port: decodes signed {y,x}
// offsets on head flits, picks an output port by dimension-order routing,
// rewrites the offset one hop closer to zero and locks the route for the
// rest of the packet. One-deep valid/ready output register.
module route_compute_stage #(
    parameter int unsigned X_W        = 8,
    parameter int unsigned Y_W        = 8,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ROUTE_MODE = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_head,
    input  logic              in_tail,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_head,
    output logic              out_tail,
    output logic [DATA_W-1:0] out_data,
    output logic [2:0]        out_port,
    output logic [4:0]        out_req,
    output logic              err_pulse
);

    typedef enum logic {StIdle, StLocked} state_e;

    localparam logic [X_W-1:0] XOne = X_W'(1);
    localparam logic [Y_W-1:0] YOne = Y_W'(1);

    state_e            state_q, state_d;
    logic              valid_q, valid_d;
    logic              head_q, head_d;
    logic              tail_q, tail_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [2:0]        port_q, port_d;
    logic [4:0]        req_q, req_d;
    logic              err_q, err_d;
    logic [2:0]        route_port_q, route_port_d;
    logic [4:0]        route_req_q, route_req_d;

    logic              accept;
    logic [X_W-1:0]    x_off, x_new;
    logic [Y_W-1:0]    y_off, y_new;
    logic              x_nz, y_nz, take_x, take_y;
    logic [2:0]        hd_port;
    logic [4:0]        hd_req;
    logic [DATA_W-1:0] hd_data;

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Head-flit route decision and one-hop offset rewrite.
    always_comb begin
        x_off   = in_data[X_W-1:0];
        y_off   = in_data[X_W+Y_W-1:X_W];
        x_nz    = (x_off != '0);
        y_nz    = (y_off != '0);
        // XY resolves x whenever it is nonzero; YX only once y is zero.
        take_x  = x_nz && ((ROUTE_MODE == 0) || !y_nz);
        take_y  = y_nz && !take_x;
        x_new   = x_off;
        y_new   = y_off;
        hd_port = 3'd1;
        hd_req  = 5'b00001;
        if (take_x) begin
            if (x_off[X_W-1]) begin
                hd_port = 3'd5;
                hd_req  = 5'b10000;
                x_new   = x_off + XOne;
            end else begin
                hd_port = 3'd4;
                hd_req  = 5'b01000;
                x_new   = x_off - XOne;
            end
        end else if (take_y) begin
            if (y_off[Y_W-1]) begin
                hd_port = 3'd3;
                hd_req  = 5'b00100;
                y_new   = y_off + YOne;
            end else begin
                hd_port = 3'd2;
                hd_req  = 5'b00010;
                y_new   = y_off - YOne;
            end
        end
        hd_data                  = in_data;
        hd_data[X_W+Y_W-1:0]     = {y_new, x_new};
    end

    // Packet FSM, route lock and output-register next state.
    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        head_d       = head_q;
        tail_d       = tail_q;
        data_d       = data_q;
        port_d       = port_q;
        req_d        = req_q;
        err_d        = 1'b0;
        route_port_d = route_port_q;
        route_req_d  = route_req_q;

        // Drained with nothing new: clear the request so it never asserts idle.
        if (valid_q && out_ready) begin
            valid_d = 1'b0;
            port_d  = 3'd0;
            req_d   = 5'b0;
        end

        if (accept) begin
            if (in_head) begin
                err_d        = (state_q == StLocked);
                state_d      = in_tail ? StIdle : StLocked;
                route_port_d = hd_port;
                route_req_d  = hd_req;
                valid_d      = 1'b1;
                head_d       = 1'b1;
                tail_d       = in_tail;
                data_d       = hd_data;
                port_d       = hd_port;
                req_d        = hd_req;
            end else if (state_q == StIdle) begin
                // Orphan body/tail: dropped.
                err_d = 1'b1;
            end else begin
                if (in_tail) begin
                    state_d = StIdle;
                end
                valid_d = 1'b1;
                head_d  = 1'b0;
                tail_d  = in_tail;
                data_d  = in_data;
                port_d  = route_port_q;
                req_d   = route_req_q;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            valid_q      <= 1'b0;
            head_q       <= 1'b0;
            tail_q       <= 1'b0;
            data_q       <= '0;
            port_q       <= 3'd0;
            req_q        <= 5'b0;
            err_q        <= 1'b0;
            route_port_q <= 3'd0;
            route_req_q  <= 5'b0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            data_q       <= data_d;
            port_q       <= port_d;
            req_q        <= req_d;
            err_q        <= err_d;
            route_port_q <= route_port_d;
            route_req_q  <= route_req_d;
        end
    end

    assign out_valid = valid_q;
    assign out_head  = head_q;
    assign out_tail  = tail_q;
    assign out_data  = data_q;
    assign out_port  = port_q;
    assign out_req   = req_q;
    assign err_pulse = err_q;

endmodule
